spi_count_slave_rx: RTL
=======================

// Module: spi_count_slave_rx
// PURPOSE
//  SPI mode-0 slave receiver: the far end of the 16-bit counter link. Samples SCLK/MOSI/SS
//  from an external SPI master, rebuilds the count word sent as two MSB-first bytes
//  (upper byte, then lower byte) within one SS-low frame.
//  Presents the word on rx_data with a one-cycle rx_valid strobe for display/downstream logic.
// PARAMETERS
//  SYNC_STAGES  2   flops per input synchronizer for sclk/mosi/ss_n (min 2)
//  WORD_W       16  received word width; must be 16 (two bytes); other values unsupported
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  sclk       in   1       SPI clock from master, async to clk, idle low (CPOL=0)
//  mosi       in   1       SPI data from master, async to clk
//  ss_n       in   1       SPI slave select, active-low, async to clk
//  rx_data    out  16      last complete word, {byte0,byte1}; held between frames
//  rx_valid   out  1       one-clk pulse: rx_data updated this cycle
//  busy       out  1       1 while a frame is in progress (synced ss_n low)
//  frame_err  out  1       only with SPI_SLV_FRAME_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset values: rx_data=16'h0000, rx_valid=0, busy=0, frame_err=0, FSM=IDLE, shift reg=0,
//   bit count=0; sync flops reset to idle levels (sclk=0, mosi=0, ss_n=1).
//  Reset mid-frame: all progress discarded; no rx_valid; next frame needs a fresh ss_n fall.
//  Input path: each of sclk/mosi/ss_n through SYNC_STAGES flops; one extra flop on sclk and
//   ss_n for edge detection. sclk_rise = synced 0->1; ss_fall / ss_rise likewise.
//  Mode 0: mosi sampled (synced copy) on sclk_rise; shift left, LSB-in, MSB first.
//  Constraint: sclk period >= 8 clk periods, high/low phases >= 3 clk each;
//   mosi stable >= SYNC_STAGES+1 clk around sclk rising edge.
//  FSM states:
//   IDLE     : wait ss_fall -> RECV_HI; clear bit count. sclk_rise in IDLE ignored.
//   RECV_HI  : shift 8 bits; on 8th sclk_rise latch hi byte -> RECV_LO.
//   RECV_LO  : shift 8 bits; on 16th sclk_rise: rx_data <= {hi, lo}, rx_valid=1
//              in the following clk -> WAIT_SS.
//   WAIT_SS  : further sclk_rise ignored (overrun); ss_rise -> IDLE.
//   ss_rise in RECV_HI/RECV_LO (abort): -> IDLE, word discarded, rx_data unchanged.
//  Simultaneous ss_rise and 16th sclk_rise in same clk: word accepted (sclk wins), then IDLE.
//  ss_fall while not IDLE cannot occur (needs ss_rise first); ss_rise in IDLE ignored.
//  Latency: rx_valid high exactly SYNC_STAGES+2 clk after the first clk edge that
//   samples the 16th sclk high at the pin.
//  rx_valid never high two consecutive cycles; at most one rx_valid per frame.
//  busy = synced ss_n low, registered (busy follows pin with SYNC_STAGES+1 latency).
//  Bit counter 5 bits, saturates at 16; no wrap.
// CONFIGURATION
//  SPI_SLV_FRAME_ERR_EN defined: frame_err port exists; one-clk pulse on ss_rise when frame
//   ended with 1..15 bits received (abort) or >16 sclk_rise seen (overrun).
//   Overrun frame still delivers its first 16 bits via rx_valid. 0-bit frame: no error.
//  Not defined: no frame_err port; aborts/overruns silently discarded/ignored as above.
// TESTING
//  1 frame 16'h1234 (0x12,0x34), sclk=clk/10 -> rx_data=16'h1234, single rx_valid pulse,
//    at SYNC_STAGES+2 clk after 16th sclk rise; busy high during frame.
//  2 back-to-back frames 16'h00FF then 16'hFF00, 4-clk ss_n high gap -> two rx_valid
//    pulses, rx_data 16'h00FF then 16'hFF00.
//  3 after 16'hA5A5, frame with 8 bits (0x3C) then ss_n high -> no rx_valid,
//    rx_data stays 16'hA5A5; with _EN frame_err pulses once.
//  4 frame of 17 bits, first 16 = 16'hBEEF -> rx_data=16'hBEEF, one rx_valid, extra bit
//    ignored; with _EN frame_err pulses on ss_n rise; next frame 16'h0001 received correctly.
//  5 reset asserted after 10 bits of 16'h5555 -> outputs to reset values immediately;
//    after release a full 16'h8001 frame -> rx_data=16'h8001.
//  6 sclk toggled 8x with ss_n high -> no rx_valid, busy=0, frame_err=0.

Source files
------------

// File: rtl/spi_count_slave_rx.sv
// spi_count_slave_rx: SPI mode-0 slave receiver for the 16-bit counter link.
// Rebuilds a word sent as two MSB-first bytes (upper, then lower) within one
// SS-low frame and presents it on rx_data with a one-cycle rx_valid strobe.
// Optional feature macro: SPI_SLV_FRAME_ERR_EN adds the frame_err output,
// which pulses on ss_n rise after an aborted (1..15 bits) or overrun (>16) frame.
module spi_count_slave_rx #(
  parameter int SYNC_STAGES = 2,   // synchronizer depth, minimum 2
  parameter int WORD_W      = 16   // must stay 16: the framing is two bytes
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  typedef enum logic [1:0] {IDLE, RECV_HI, RECV_LO, WAIT_SS} state_t;

  localparam logic [4:0] BYTE_LAST = 5'd7;
  localparam logic [4:0] WORD_LAST = 5'd15;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic sclk_prev_q, ss_prev_q;
  logic sclk_rise_q, ss_fall_q, ss_rise_q, mosi_q;
  logic busy_q;
  logic [4:0] bit_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic word_done_d, word_done_q;
  logic rx_valid_q;
  logic [WORD_W-1:0] rx_data_q;
  logic receiving;

  wire sclk_s = sclk_sync_q[SYNC_STAGES-1];
  wire mosi_s = mosi_sync_q[SYNC_STAGES-1];
  wire ss_s   = ss_sync_q[SYNC_STAGES-1];

  assign receiving = (state_q == RECV_HI) || (state_q == RECV_LO);

  // Synchronize the asynchronous SPI pins; flops reset to the idle bus levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    end
  end

  // Edge detection; edges and the data bit are registered together so the
  // FSM sees sclk and ss events on the same, aligned cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      ss_fall_q   <= ~ss_s & ss_prev_q;
      ss_rise_q   <= ss_s & ~ss_prev_q;
      mosi_q      <= mosi_s;
      busy_q      <= ~ss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: an ss rise aborts a frame unless it coincides with the
  // 16th sclk rise, in which case the word is still accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall_q) state_d = RECV_HI;
      RECV_HI: begin
        if (ss_rise_q)                                  state_d = IDLE;
        else if (sclk_rise_q && bit_cnt_q == BYTE_LAST) state_d = RECV_LO;
      end
      RECV_LO: begin
        if (sclk_rise_q && bit_cnt_q == WORD_LAST) state_d = ss_rise_q ? IDLE : WAIT_SS;
        else if (ss_rise_q)                        state_d = IDLE;
      end
      WAIT_SS: if (ss_rise_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: word completion strobe (and frame error when enabled).
`ifdef SPI_SLV_FRAME_ERR_EN
  logic overrun_q;
  logic frame_err_d, frame_err_q;
`endif
  always_comb begin
    word_done_d = (state_q == RECV_LO) && sclk_rise_q && (bit_cnt_q == WORD_LAST);
`ifdef SPI_SLV_FRAME_ERR_EN
    frame_err_d = 1'b0;
    if (ss_rise_q) begin
      if (receiving)
        frame_err_d = ((bit_cnt_q != 5'd0) || sclk_rise_q) && !word_done_d;
      else if (state_q == WAIT_SS)
        frame_err_d = overrun_q || sclk_rise_q;
    end
`endif
  end

  // Shift register and bit counter; the counter stops at 16 because it only
  // advances while receiving, and reception ends on the 16th bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= '0;
    end else if (state_q == IDLE) begin
      if (ss_fall_q) bit_cnt_q <= 5'd0;
    end else if (receiving && sclk_rise_q) begin
      shift_q   <= {shift_q[WORD_W-2:0], mosi_q};
      bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  // Overrun tracking and the registered error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      if (state_q == IDLE && ss_fall_q)          overrun_q <= 1'b0;
      else if (state_q == WAIT_SS && sclk_rise_q) overrun_q <= 1'b1;
    end
  end
  assign frame_err = frame_err_q;
`endif

  // Output stage: the word is published one clock after completion, together
  // with the rx_valid strobe; rx_data holds between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      word_done_q <= word_done_d;
      rx_valid_q  <= word_done_q;
      if (word_done_q) rx_data_q <= shift_q;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
